// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction-fetch stage of the 32-bit CPU.
//
// Owns the program counter, drives the combinational instruction ROM address
// and registers the returned word into the IF/ID pipeline register. A small
// run-control FSM (IDLE -> RUN -> HALT) gates fetching. Decoder stall holds
// the stage. Branch/jump redirect loads a new PC and inserts a bubble.
//
// Ports
//   clk            in   1       rising-edge clock
//   rst            in   1       synchronous active-high reset
//   start          in   1       pulse: leave IDLE and begin fetching
//   halt           in   1       level: stop fetching, enter terminal HALT
//   stall          in   1       decoder not ready: hold PC and IF/ID
//   redirect       in   1       branch/jump taken: load redirect_addr, flush
//   redirect_addr  in   ADDR_W  redirect target word address
//   a              out  ADDR_W  ROM address (combinational, equals pc)
//   inst           in   32      ROM data for address a (same cycle)
//   id_inst        out  32      registered instruction to the decoder
//   id_pc          out  ADDR_W  address id_inst was fetched from
//   id_valid       out  1       id_inst holds a real fetched instruction
//   running        out  1       FSM is in RUN
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int unsigned           ADDR_W   = 6,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] a,
  input  logic [31:0]       inst,
  output logic [31:0]       id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              running
);

  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   pc_q,       pc_d;
  logic [INST_W-1:0]   id_inst_q,  id_inst_d;
  logic [ADDR_W-1:0]   id_pc_q,    id_pc_d;
  logic                id_valid_q, id_valid_d;
  logic                running_q,  running_d;

  // State and pipeline registers; reset discards any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      id_inst_q  <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      running_q  <= running_d;
    end
  end

  // Next-state logic. Priority inside RUN: halt > redirect > stall > fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        // No capture in the cycle start is seen; fetching begins next edge.
        id_valid_d = 1'b0;
        if (halt) begin
          state_d = ST_HALT;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (halt) begin
          // Any same-cycle redirect is dropped; pc keeps its value.
          state_d    = ST_HALT;
          id_valid_d = 1'b0;
          id_inst_d  = '0;
        end else if (redirect) begin
          // Bubble: the word at the old pc is never delivered.
          pc_d       = redirect_addr;
          id_valid_d = 1'b0;
          id_inst_d  = '0;
        end else if (!stall) begin
          id_inst_d  = inst;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_q + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        end
      end

      ST_HALT: begin
        // Terminal until reset; everything holds.
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  assign a        = pc_q;
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;
  assign running  = running_q;

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch: directed scenarios
// followed by randomized traffic, compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, start, halt, stall, redirect;
  logic [5:0]  redirect_addr;
  logic [5:0]  a;
  logic [31:0] inst;
  logic [31:0] id_inst;
  logic [5:0]  id_pc;
  logic        id_valid;
  logic        running;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_pc;
  logic [31:0] m_inst;
  int          m_idpc;
  logic        m_valid;
  logic        m_running;
  logic        m_halted;

  always #5 clk = ~clk;

  // Combinational ROM model
  assign inst = 32'hA500_0000 | 32'(a);

  inst_fetch dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .a(a), .inst(inst),
    .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid), .running(running)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom(input int addr);
    return 32'hA500_0000 | 32'(addr);
  endfunction

  // Apply one edge of the spec's rules to the model, using current inputs.
  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_inst = 32'h0; m_idpc = 0; m_valid = 1'b0;
      m_running = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      // terminal
    end else if (!m_running) begin
      m_valid = 1'b0;
      if (halt) m_halted = 1'b1;
      else if (start) m_running = 1'b1;
    end else if (halt) begin
      m_running = 1'b0; m_halted = 1'b1; m_valid = 1'b0; m_inst = 32'h0;
    end else if (redirect) begin
      m_pc = int'(redirect_addr); m_valid = 1'b0; m_inst = 32'h0;
    end else if (!stall) begin
      m_inst = rom(m_pc); m_idpc = m_pc; m_valid = 1'b1;
      m_pc = (m_pc + 1) % 64;
    end
  endtask

  // One clock: let the DUT take the edge, advance the model, compare all outputs.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".a"},        32'(a),        32'(m_pc));
    chk({tag, ".id_inst"},  id_inst,       m_inst);
    chk({tag, ".id_pc"},    32'(id_pc),    32'(m_idpc));
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(m_valid));
    chk({tag, ".running"},  32'(running),  32'(m_running));
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; halt = 0; stall = 0; redirect = 0; redirect_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick("reset");
    rst = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick("start");
    start = 0;
  endtask

  initial begin
    int guard;
    idle_inputs();
    m_pc = 0; m_inst = 0; m_idpc = 0; m_valid = 0; m_running = 0; m_halted = 0;
    @(negedge clk);

    // Reset state and IDLE
    do_reset();
    chk("rst_a", 32'(a), 32'h0);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    tick("idle0");
    tick("idle1");
    chk("idle_valid", 32'(id_valid), 32'h0);

    // Start: no capture on the start edge, then 0,1,2
    do_start();
    chk("start_nocap", 32'(id_valid), 32'h0);
    chk("start_run", 32'(running), 32'h1);
    tick("seq0"); chk("seq0_inst", id_inst, 32'hA500_0000);
    tick("seq1"); chk("seq1_inst", id_inst, 32'hA500_0001);
    tick("seq2"); chk("seq2_inst", id_inst, 32'hA500_0002);

    // Advance to id_pc=5, then stall three cycles
    guard = 0;
    while (!(id_valid && id_pc == 6'd5) && guard < 20) begin
      tick("to5"); guard++;
    end
    chk("reach_pc5", 32'(id_pc), 32'd5);
    stall = 1;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("stall_inst", id_inst, 32'hA500_0005);
    chk("stall_valid", 32'(id_valid), 32'h1);
    chk("stall_a", 32'(a), 32'd6);
    stall = 0;
    tick("unstall");
    chk("unstall_pc", 32'(id_pc), 32'd6);

    // Redirect wins over stall
    stall = 1; redirect = 1; redirect_addr = 6'h20;
    tick("redir");
    chk("redir_valid", 32'(id_valid), 32'h0);
    chk("redir_inst", id_inst, 32'h0);
    chk("redir_a", 32'(a), 32'h20);
    stall = 0; redirect = 0;
    tick("redir_cap");
    chk("redir_cap_pc", 32'(id_pc), 32'h20);
    chk("redir_cap_inst", id_inst, 32'hA500_0020);

    // Wrap 62,63,0,1
    redirect = 1; redirect_addr = 6'd62;
    tick("wrap_redir");
    redirect = 0;
    tick("wrap62"); chk("wrap62_pc", 32'(id_pc), 32'd62);
    tick("wrap63"); chk("wrap63_pc", 32'(id_pc), 32'd63);
    tick("wrap0");  chk("wrap0_pc",  32'(id_pc), 32'd0);
    tick("wrap1");  chk("wrap1_pc",  32'(id_pc), 32'd1);

    // Reset mid-RUN at pc=0x15
    redirect = 1; redirect_addr = 6'h15;
    tick("pre_rst");
    redirect = 0;
    chk("pre_rst_a", 32'(a), 32'h15);
    rst = 1;
    tick("mid_rst");
    rst = 0;
    chk("mid_rst_a", 32'(a), 32'h0);
    chk("mid_rst_valid", 32'(id_valid), 32'h0);
    chk("mid_rst_running", 32'(running), 32'h0);

    // Halt with simultaneous redirect; then start/redirect ignored
    do_start();
    tick("h_run0"); tick("h_run1"); tick("h_run2");
    halt = 1; redirect = 1; redirect_addr = 6'h30;
    tick("halt");
    chk("halt_running", 32'(running), 32'h0);
    chk("halt_valid", 32'(id_valid), 32'h0);
    chk("halt_a", 32'(a), 32'd3);
    halt = 0; start = 1;
    tick("halt_ign0"); tick("halt_ign1");
    chk("halt_ign_a", 32'(a), 32'd3);
    chk("halt_ign_running", 32'(running), 32'h0);
    start = 0; redirect = 0;
    do_reset();
    chk("halt_rst_a", 32'(a), 32'h0);
    chk("halt_rst_running", 32'(running), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(99) == 0);
      start         = ($urandom_range(7) == 0);
      halt          = ($urandom_range(59) == 0);
      stall         = ($urandom_range(3) == 0);
      redirect      = ($urandom_range(7) == 0);
      redirect_addr = 6'($urandom);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
